// File: rtl/sc_time_pkg.sv
// Shared time-base definitions for the game-time countdown register.
package sc_time_pkg;

   localparam logic [1:0] StateEncIdle    = 2'd0;
   localparam logic [1:0] StateEncRun     = 2'd1;
   localparam logic [1:0] StateEncPause   = 2'd2;
   localparam logic [1:0] StateEncExpired = 2'd3;

   typedef enum logic [1:0] {
      stIdle    = StateEncIdle,
      stRun     = StateEncRun,
      stPause   = StateEncPause,
      stExpired = StateEncExpired
   } countdownStateT;

   // CLOCK_50 cycles per second of game time.
   localparam int unsigned DefaultPrescaler = 50_000_000;
   // Short time base used by simulation benches.
   localparam int unsigned SimPrescaler     = 4;

endpackage

// File: rtl/sc_tick_prescaler.sv
// Free-running modulo-Prescaler counter with synchronous clear, enable and
// a registered active-low wrap strobe.
module sc_tick_prescaler
   import sc_time_pkg::*;
#(
   parameter int unsigned Prescaler = DefaultPrescaler
) (
   input  logic SC_TickPrescaler_CLOCK_50,
   input  logic SC_TickPrescaler_clear_InHigh,
   input  logic SC_TickPrescaler_enable_InHigh,
   output logic SC_TickPrescaler_atTerminal_c,
   output logic SC_TickPrescaler_wrap_OutLow
);

   localparam int unsigned CountW = (Prescaler > 1) ? $clog2(Prescaler) : 1;

   logic [CountW-1:0] countQ;

   // Last phase of the period; the owner decides whether it is consumed.
   assign SC_TickPrescaler_atTerminal_c = (countQ == CountW'(Prescaler - 1));

   // Phase counter and wrap strobe; clear dominates enable.
   always_ff @(posedge SC_TickPrescaler_CLOCK_50) begin
      if (SC_TickPrescaler_clear_InHigh) begin
         countQ                       <= '0;
         SC_TickPrescaler_wrap_OutLow <= 1'b1;
      end else if (SC_TickPrescaler_enable_InHigh) begin
         if (SC_TickPrescaler_atTerminal_c) begin
            countQ <= '0;
         end else begin
            countQ <= countQ + CountW'(1);
         end
         SC_TickPrescaler_wrap_OutLow <= ~SC_TickPrescaler_atTerminal_c;
      end else begin
         SC_TickPrescaler_wrap_OutLow <= 1'b1;
      end
   end

endmodule

// File: rtl/sc_regcountdown_time.sv
// Game-time countdown register: loads INIT on start, decrements once per
// prescaled period while running, and flags expiry at zero.
module sc_regcountdown_time
   import sc_time_pkg::*;
#(
   parameter int unsigned                     RegCOUNTDOWN_DATAWIDTH = 8,
   parameter logic [RegCOUNTDOWN_DATAWIDTH-1:0] RegCOUNTDOWN_INIT      = RegCOUNTDOWN_DATAWIDTH'(99),
   parameter int unsigned                     RegCOUNTDOWN_PRESCALER = DefaultPrescaler
) (
   input  logic                              SC_RegCOUNTDOWN_Time_CLOCK_50,
   input  logic                              SC_RegCOUNTDOWN_Time_RESET_InHigh,
   input  logic                              SC_RegCOUNTDOWN_Time_start_InLow,
   input  logic                              SC_RegCOUNTDOWN_Time_pause_InLow,
   output logic [RegCOUNTDOWN_DATAWIDTH-1:0] SC_RegCOUNTDOWN_Time_data_OutBUS,
   output logic                              SC_RegCOUNTDOWN_Time_tick_OutLow,
   output logic                              SC_RegCOUNTDOWN_Time_expired_OutHigh
);

   localparam int unsigned DataW = RegCOUNTDOWN_DATAWIDTH;

   countdownStateT   stateQ;
   countdownStateT   stateD;
   logic [DataW-1:0] dataQ;
   logic             expiredQ;
   logic             initIsZero_c;
   logic             prescClear_c;
   logic             countEn_c;
   logic             atTerminal_c;
   logic             advance_c;
   logic             lastStep_c;
   logic             tickLow;

   assign initIsZero_c = (RegCOUNTDOWN_INIT == '0);

   // Start reloads the time base; reset does the same.
   assign prescClear_c = SC_RegCOUNTDOWN_Time_RESET_InHigh | ~SC_RegCOUNTDOWN_Time_start_InLow;

   // The time base advances on every edge that sees pause released while
   // counting, including the edge that leaves PAUSE.
   assign countEn_c  = SC_RegCOUNTDOWN_Time_start_InLow & SC_RegCOUNTDOWN_Time_pause_InLow &
                       ((stateQ == stRun) | (stateQ == stPause));
   assign advance_c  = countEn_c & atTerminal_c & (dataQ != '0);
   assign lastStep_c = advance_c & (dataQ == DataW'(1));

   sc_tick_prescaler #(
      .Prescaler (RegCOUNTDOWN_PRESCALER)
   ) u_tickPrescaler (
      .SC_TickPrescaler_CLOCK_50      (SC_RegCOUNTDOWN_Time_CLOCK_50),
      .SC_TickPrescaler_clear_InHigh  (prescClear_c),
      .SC_TickPrescaler_enable_InHigh (countEn_c),
      .SC_TickPrescaler_atTerminal_c  (atTerminal_c),
      .SC_TickPrescaler_wrap_OutLow   (tickLow)
   );

   // State register.
   always_ff @(posedge SC_RegCOUNTDOWN_Time_CLOCK_50) begin
      if (SC_RegCOUNTDOWN_Time_RESET_InHigh) begin
         stateQ <= stIdle;
      end else begin
         stateQ <= stateD;
      end
   end

   // Next-state logic: start overrides everything below reset.
   always_comb begin
      stateD = stateQ;
      if (!SC_RegCOUNTDOWN_Time_start_InLow) begin
         stateD = initIsZero_c ? stExpired : stRun;
      end else begin
         case (stateQ)
            stIdle: begin
               stateD = stIdle;
            end
            stRun: begin
               if (!SC_RegCOUNTDOWN_Time_pause_InLow) begin
                  stateD = stPause;
               end else if (lastStep_c) begin
                  stateD = stExpired;
               end
            end
            stPause: begin
               if (SC_RegCOUNTDOWN_Time_pause_InLow) begin
                  stateD = lastStep_c ? stExpired : stRun;
               end
            end
            stExpired: begin
               stateD = stExpired;
            end
            default: begin
               stateD = stIdle;
            end
         endcase
      end
   end

   // Remaining-time register; saturates at zero.
   always_ff @(posedge SC_RegCOUNTDOWN_Time_CLOCK_50) begin
      if (SC_RegCOUNTDOWN_Time_RESET_InHigh || !SC_RegCOUNTDOWN_Time_start_InLow) begin
         dataQ <= RegCOUNTDOWN_INIT;
      end else if (advance_c) begin
         dataQ <= dataQ - DataW'(1);
      end
   end

   // Expiry flag, registered alongside the state it reports.
   always_ff @(posedge SC_RegCOUNTDOWN_Time_CLOCK_50) begin
      if (SC_RegCOUNTDOWN_Time_RESET_InHigh) begin
         expiredQ <= 1'b0;
      end else begin
         expiredQ <= (stateD == stExpired);
      end
   end

   assign SC_RegCOUNTDOWN_Time_data_OutBUS     = dataQ;
   assign SC_RegCOUNTDOWN_Time_tick_OutLow     = tickLow;
   assign SC_RegCOUNTDOWN_Time_expired_OutHigh = expiredQ;

endmodule
